data_memory_be: RTL and testbench
=================================

Name: data_memory_be

Overview:
Parametrised data memory for the MIPS datapath, successor to the word-only data_memory. It adds byte/halfword/word access with sign or zero extension, misalignment detection, configurable read latency with a ready handshake, and a sequenced clear-after-reset. It keeps the MemtoReg bypass: when MemtoReg=0, a read returns the address instead of memory data.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, minimum 4.
READ_LAT, 1, read latency in cycles; legal values are 1 or 2.
CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = memory contents survive reset.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
address  in  32  byte address.
write_data  in  32  store data, right-aligned.
MemRead  in  1  read request.
MemWrite  in  1  write request.
MemtoReg  in  1  1 = return memory data; 0 = return the address.
size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
sign_ext  in  1  for byte/half reads: 1 = sign-extend, 0 = zero-extend.
read_data  out  32  registered read result.
ready  out  1  block accepts a request this cycle.
misaligned  out  1  one-cycle pulse when a request is rejected as misaligned.

Behaviour:
- Reset (rst=0 at a rising edge):
  - read_data=0, ready=0, misaligned=0.
  - FSM goes to CLEAR, clear pointer = 0; the pointer holds at 0 while rst stays 0.
  - Any pending read is dropped.
  - Reset asserted during CLEAR restarts the clear from word 0.
- FSM states: CLEAR, IDLE, BUSY.
- CLEAR (CLEAR_ON_RESET=1):
  - After rst returns to 1, writes zero to one word per cycle, word 0 first.
  - Takes exactly DEPTH_WORDS cycles, then moves to IDLE; ready=1 from the first IDLE cycle.
- CLEAR (CLEAR_ON_RESET=0): moves to IDLE one cycle after rst returns to 1; contents untouched.
- Request acceptance:
  - A request is accepted only at an edge where state is IDLE and ready=1.
  - Requests while ready=0 are ignored; there is no queue.
- Addressing:
  - Word index = address[log2(DEPTH_WORDS)+1:2].
  - Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Alignment:
  - A half access is misaligned when address[0]=1.
  - A word access is misaligned when address[1:0]!=0.
  - Bytes are never misaligned.
  - Misaligned request: no memory write, read_data holds, misaligned=1 for exactly the cycle after acceptance.
  - The alignment check applies only when the request reaches memory (MemWrite=1, or MemRead=1 with MemtoReg=1).
- Writes:
  - Committed at the accepting edge, using byte enables.
  - sb writes write_data[7:0] to lane address[1:0].
  - sh writes write_data[15:0] to lanes {address[1],0} and {address[1],1}.
  - sw writes all four lanes.
  - Lane 0 = bits 7:0; little-endian.
- MemRead and MemWrite both 1: the write is performed, the read is ignored, read_data holds.
- Reads, READ_LAT=1:
  - read_data is updated at the accepting edge.
  - ready stays 1, so back-to-back reads proceed every cycle.
- Reads, READ_LAT=2:
  - The accepting edge moves the FSM to BUSY with ready=0.
  - read_data is updated at the next edge; the FSM returns to IDLE and ready=1.
- Read data path:
  - The selected byte/half is extracted by address[1:0] / address[1], right-aligned, then extended per sign_ext.
  - Words are returned unchanged.
- MemtoReg=0 with MemRead=1: read_data loads address with the same latency; no extension and no alignment check.
- read_data holds its value whenever no read completes.
- Read-after-write: a write at edge N followed by a read accepted at edge N+1 to the same word returns the new data.

Test Plan:
- Reset and clear, DEPTH_WORDS=16, CLEAR_ON_RESET=1: hold rst=0 for 3 cycles, then release → ready=0 for exactly 16 cycles, then 1; a word read of 0x3C returns 00000000.
- Word write/read, READ_LAT=1: sw DEADBEEF @0x04, then lw @0x04 with MemtoReg=1 → read_data=DEADBEEF; the same read with MemtoReg=0 → 00000004.
- Sub-word access:
  - After sw CAFEBABE @0x08: lb @0x09 sign_ext=1 → FFFFFFBA; lbu @0x09 → 000000BA; lh @0x0A sign_ext=1 → FFFFCAFE.
  - Then sb 0x11 @0x0B → lw @0x08 returns 11FEBABE.
- Misalignment:
  - sw 12345678 @0x06 → misaligned pulses high for 1 cycle and word 1 is unchanged.
  - lh @0x0D → misaligned=1 and read_data holds its previous value.
- Latency, READ_LAT=2: lw @0x04 → ready=0 for one cycle, DEADBEEF appears 2 edges after acceptance; a request presented during BUSY is ignored.
- Reset and wrap, DEPTH_WORDS=16:
  - Assert rst during CLEAR at pointer 5 → clear restarts and runs the full 16 cycles.
  - Write @0x44 then read @0x04 → same word (wrap-around); the read returns the value written @0x44.

Source files
------------

// File: rtl/data_memory_be.sv
// Purpose : byte-enabled MIPS data memory with sized/sign-extended reads, misalignment reject, sequenced clear.
// Latency : stores commit at the accepting edge; reads return READ_LAT (1 or 2) edges after acceptance.
// Backpr. : ready=0 while clearing or while a 2-cycle read is in flight; requests seen with ready=0 are dropped.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   address         byte address (upper bits beyond the memory wrap)
//   write_data      store data, right-aligned
//   MemRead/MemWrite read / write request (write wins if both)
//   MemtoReg        1 = return memory data, 0 = return the address itself
//   size, sign_ext  00 byte, 01 half, 1x word; extension for sub-word reads
//   read_data       registered read result
//   ready           request can be accepted this cycle
//   misaligned      one-cycle pulse after a rejected misaligned request
module data_memory_be #(
    parameter int DEPTH_WORDS    = 256,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] clr_ptr;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] word_idx;
    logic          is_half;
    logic          is_word;
    logic          accept;
    logic          mem_access;
    logic          align_err;
    logic          do_write;
    logic          do_read;
    logic          clr_we;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;

    // Read-in-flight context for the two-cycle read path.
    logic [31:0]   pend_word;
    logic [1:0]    pend_lane;
    logic [1:0]    pend_size;
    logic          pend_sx;
    logic          pend_raw;

    // Picks the addressed byte/half out of a word and extends it. When raw
    // is set the value is the bypassed address and passes through untouched.
    function automatic logic [31:0] shape_read(
        input logic [31:0] w,
        input logic [1:0]  lane,
        input logic [1:0]  sz,
        input logic        sx,
        input logic        raw
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        if (raw) begin
            r = w;
        end else begin
            case (sz)
                2'b00:   r = {{24{sx & b[7]}}, b};
                2'b01:   r = {{16{sx & h[15]}}, h};
                default: r = w;
            endcase
        end
        return r;
    endfunction

    assign ready      = (state == IDLE);
    assign word_idx   = address[AW+1:2];
    assign is_half    = (size == 2'b01);
    assign is_word    = size[1];
    assign accept     = rst && (state == IDLE);
    // Address-bypass reads never touch memory, so they are never misaligned.
    assign mem_access = MemWrite | (MemRead & MemtoReg);
    assign align_err  = mem_access & ((is_half & address[0]) | (is_word & (address[1:0] != 2'b00)));
    assign do_write   = accept & MemWrite & ~align_err;
    assign do_read    = accept & MemRead & ~MemWrite & ~align_err;
    assign clr_we     = rst && (state == CLEAR) && (CLEAR_ON_RESET != 0);

    always_comb begin
        be        = 4'b0000;
        wdata_rep = write_data;
        case (size)
            2'b00: begin
                be[address[1:0]] = 1'b1;
                wdata_rep        = {4{write_data[7:0]}};
            end
            2'b01: begin
                be        = address[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{write_data[15:0]}};
            end
            default: begin
                be = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR: begin
                if (CLEAR_ON_RESET == 0 || clr_ptr == AW'(DEPTH_WORDS - 1)) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (do_read && READ_LAT == 2) begin
                    state_nxt = BUSY;
                end
            end
            BUSY:    state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Storage has no reset; zeroing is done one word per cycle by the clear
    // sequence so the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_ptr] <= '0;
        end else if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_read) begin
            pend_word <= MemtoReg ? mem[word_idx] : address;
            pend_lane <= address[1:0];
            pend_size <= size;
            pend_sx   <= sign_ext;
            pend_raw  <= ~MemtoReg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            read_data  <= '0;
            misaligned <= 1'b0;
            clr_ptr    <= '0;
        end else begin
            misaligned <= accept & align_err;
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
            if (READ_LAT == 1) begin
                if (do_read) begin
                    read_data <= shape_read(MemtoReg ? mem[word_idx] : address,
                                            address[1:0], size, sign_ext, ~MemtoReg);
                end
            end else if (state == BUSY) begin
                read_data <= shape_read(pend_word, pend_lane, pend_size, pend_sx, pend_raw);
            end
        end
    end

endmodule

// File: tb/tb_data_memory_be.sv
module tb_data_memory_be;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic        MemtoReg = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;

    logic [31:0] rd0, rd1;
    logic        rdy0, rdy1, mis0, mis1;

    always #5 clk = ~clk;

    // Instance 0: single-cycle reads, cleared on reset.
    data_memory_be #(.DEPTH_WORDS(16), .READ_LAT(1), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .size(size), .sign_ext(sign_ext),
        .read_data(rd0), .ready(rdy0), .misaligned(mis0)
    );

    // Instance 1: two-cycle reads, contents survive reset.
    data_memory_be #(.DEPTH_WORDS(16), .READ_LAT(2), .CLEAR_ON_RESET(0)) dut1 (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .size(size), .sign_ext(sign_ext),
        .read_data(rd1), .ready(rdy1), .misaligned(mis1)
    );

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Behavioural model, one slot per instance.
    logic [31:0] m_mem   [2][16];
    bit          m_known [2][16];
    int          m_clr   [2];
    bit          m_busy  [2];
    logic [31:0] m_pend  [2];
    bit          m_pendk [2];
    logic [31:0] m_rd    [2];
    bit          m_rdk   [2];
    bit          m_mis   [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_clr[k] = 0; m_busy[k] = 0; m_rd[k] = '0; m_rdk[k] = 0; m_mis[k] = 0;
            m_pend[k] = '0; m_pendk[k] = 0;
            for (int w = 0; w < 16; w++) begin
                m_mem[k][w] = '0;
                m_known[k][w] = 0;
            end
        end
    end

    function automatic bit m_ready(input int k);
        return (m_clr[k] == 0) && !m_busy[k];
    endfunction

    task automatic model_step(input int k);
        int          lat, sz, idx, sh;
        bit          clr_on, touches, bad;
        logic [31:0] w, v, mask, val;
        lat    = (k == 0) ? 1 : 2;
        clr_on = (k == 0);
        idx    = int'(address[5:2]);
        sz     = (size == 2'd3) ? 2 : int'(size);
        if (!rst) begin
            m_rd[k] = '0; m_rdk[k] = 1; m_mis[k] = 0; m_busy[k] = 0;
            m_clr[k] = clr_on ? 16 : 1;
        end else if (m_clr[k] > 0) begin
            if (clr_on) begin
                m_mem[k][16 - m_clr[k]] = '0;
                m_known[k][16 - m_clr[k]] = 1;
            end
            m_clr[k]--;
            m_mis[k] = 0;
        end else if (m_busy[k]) begin
            m_rd[k] = m_pend[k]; m_rdk[k] = m_pendk[k];
            m_busy[k] = 0; m_mis[k] = 0;
        end else begin
            m_mis[k] = 0;
            touches = MemWrite || (MemRead && MemtoReg);
            bad = touches && ((sz == 1 && address[0]) || (sz == 2 && address[1:0] != 2'b00));
            if (bad) begin
                m_mis[k] = 1;
            end else if (MemWrite) begin
                if (sz == 0) begin
                    sh = 8 * int'(address[1:0]);
                    mask = 32'hFF << sh;
                end else if (sz == 1) begin
                    sh = 16 * int'(address[1]);
                    mask = 32'hFFFF << sh;
                end else begin
                    sh = 0;
                    mask = 32'hFFFF_FFFF;
                    m_known[k][idx] = 1;
                end
                val = write_data << sh;
                m_mem[k][idx] = (m_mem[k][idx] & ~mask) | (val & mask);
            end else if (MemRead) begin
                w = m_mem[k][idx];
                if (!MemtoReg) begin
                    v = address;
                end else if (sz == 0) begin
                    v = (w >> (8 * int'(address[1:0]))) & 32'hFF;
                    if (sign_ext && v >= 32'h80) v = v | 32'hFFFF_FF00;
                end else if (sz == 1) begin
                    v = (w >> (16 * int'(address[1]))) & 32'hFFFF;
                    if (sign_ext && v >= 32'h8000) v = v | 32'hFFFF_0000;
                end else begin
                    v = w;
                end
                if (lat == 1) begin
                    m_rd[k] = v; m_rdk[k] = !MemtoReg || m_known[k][idx];
                end else begin
                    m_pend[k] = v; m_pendk[k] = !MemtoReg || m_known[k][idx];
                    m_busy[k] = 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            for (int k = 0; k < 2; k++) begin
                if (((k == 0) ? rdy0 : rdy1) !== m_ready(k)) begin
                    n_fail++;
                    $display("FAIL ready[%0d] t=%0t got %b want %b", k, $time, (k == 0) ? rdy0 : rdy1, m_ready(k));
                end
                if (((k == 0) ? mis0 : mis1) !== m_mis[k]) begin
                    n_fail++;
                    $display("FAIL misaligned[%0d] t=%0t got %b want %b", k, $time, (k == 0) ? mis0 : mis1, m_mis[k]);
                end
                if (m_rdk[k] && (((k == 0) ? rd0 : rd1) !== m_rd[k])) begin
                    n_fail++;
                    $display("FAIL read_data[%0d] t=%0t got %h want %h", k, $time, (k == 0) ? rd0 : rd1, m_rd[k]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] s_rd0, s_rd1e, s_rd1;
    logic        s_mis0, s_mis1, s_rdy1;

    // One-cycle request followed by one idle cycle, so both instances are
    // ready again afterwards.
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic r, input logic wr,
                          input logic m2r, input logic [1:0] sz, input logic se);
        address = a; write_data = wd; MemRead = r; MemWrite = wr;
        MemtoReg = m2r; size = sz; sign_ext = se;
        tick();
        s_rd0 = rd0; s_mis0 = mis0; s_rd1e = rd1; s_rdy1 = rdy1; s_mis1 = mis1;
        MemRead = 1'b0; MemWrite = 1'b0;
        tick();
        s_rd1 = rd1;
    endtask

    task automatic count_clear(input string name);
        int cnt;
        cnt = 0;
        while (!rdy0 && cnt < 40) begin
            cnt++;
            tick();
        end
        chk(name, 32'(cnt), 32'd16);
    endtask

    initial begin
        repeat (3) tick();
        chk_en = 1'b1;
        chk("reset_read_data", rd0, 32'h0);
        chk("reset_ready", {31'b0, rdy0}, 32'h0);
        rst = 1'b1;
        count_clear("clear_cycles");

        do_req(32'h3C, 0, 1, 0, 1, 2'b10, 0);
        chk("clear_word_3c", s_rd0, 32'h0);

        do_req(32'h04, 32'hDEADBEEF, 0, 1, 1, 2'b10, 0);
        do_req(32'h04, 0, 1, 0, 0, 2'b10, 0);
        chk("bypass_addr", s_rd0, 32'h4);
        chk("bypass_addr_lat2", s_rd1, 32'h4);
        do_req(32'h04, 0, 1, 0, 1, 2'b10, 0);
        chk("lw_04", s_rd0, 32'hDEADBEEF);
        chk("model_lw_04", m_rd[0], 32'hDEADBEEF);
        chk("lat2_busy_ready", {31'b0, s_rdy1}, 32'h0);
        chk("lat2_early_hold", s_rd1e, 32'h4);
        chk("lat2_lw_04", s_rd1, 32'hDEADBEEF);

        do_req(32'h08, 32'hCAFEBABE, 0, 1, 1, 2'b10, 0);
        do_req(32'h09, 0, 1, 0, 1, 2'b00, 1);
        chk("lb_09", s_rd0, 32'hFFFFFFBA);
        chk("model_lb_09", m_rd[0], 32'hFFFFFFBA);
        do_req(32'h09, 0, 1, 0, 1, 2'b00, 0);
        chk("lbu_09", s_rd0, 32'h000000BA);
        do_req(32'h0A, 0, 1, 0, 1, 2'b01, 1);
        chk("lh_0a", s_rd0, 32'hFFFFCAFE);
        chk("lat2_lh_0a", s_rd1, 32'hFFFFCAFE);
        do_req(32'h0B, 32'h11, 0, 1, 1, 2'b00, 0);
        do_req(32'h08, 0, 1, 0, 1, 2'b10, 0);
        chk("sb_then_lw", s_rd0, 32'h11FEBABE);

        do_req(32'h06, 32'h12345678, 0, 1, 1, 2'b10, 0);
        chk("sw_mis_pulse", {31'b0, s_mis0}, 32'h1);
        chk("sw_mis_pulse_lat2", {31'b0, s_mis1}, 32'h1);
        chk("sw_mis_one_cycle", {31'b0, mis0}, 32'h0);
        do_req(32'h04, 0, 1, 0, 1, 2'b10, 0);
        chk("word1_unchanged", s_rd0, 32'hDEADBEEF);
        do_req(32'h0D, 0, 1, 0, 1, 2'b01, 1);
        chk("lh_mis_pulse", {31'b0, s_mis0}, 32'h1);
        chk("lh_mis_hold", s_rd0, 32'hDEADBEEF);

        // A store presented while instance 1 is busy must be dropped there.
        address = 32'h08; MemRead = 1; MemWrite = 0; MemtoReg = 1; size = 2'b10;
        tick();
        address = 32'h08; write_data = 32'hAAAAAAAA; MemRead = 0; MemWrite = 1;
        tick();
        MemWrite = 0;
        tick();
        do_req(32'h08, 0, 1, 0, 1, 2'b10, 0);
        chk("busy_write_taken_lat1", s_rd0, 32'hAAAAAAAA);
        chk("busy_write_ignored", s_rd1, 32'h11FEBABE);

        do_req(32'h44, 32'h0BADF00D, 0, 1, 1, 2'b10, 0);
        do_req(32'h04, 0, 1, 0, 1, 2'b10, 0);
        chk("wrap_44_04", s_rd0, 32'h0BADF00D);
        chk("wrap_44_04_lat2", s_rd1, 32'h0BADF00D);

        rst = 1'b0; tick(); rst = 1'b1;
        repeat (5) tick();
        rst = 1'b0; tick(); rst = 1'b1;
        count_clear("clear_restart_cycles");
        do_req(32'h04, 0, 1, 0, 1, 2'b10, 0);
        chk("cleared_word1", s_rd0, 32'h0);
        chk("kept_word1_noclear", s_rd1, 32'h0BADF00D);

        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 499) != 0);
            address    = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) address = address | ($urandom & 32'hFFFFFF00);
            write_data = $urandom;
            MemRead    = 1'($urandom_range(0, 1));
            MemWrite   = ($urandom_range(0, 3) == 0);
            MemtoReg   = ($urandom_range(0, 3) != 0);
            size       = 2'($urandom_range(0, 3));
            sign_ext   = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b1; MemRead = 0; MemWrite = 0;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
